// File: rtl/ps2_mouse_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_packet_decoder
// Purpose  : Frames PS/2 receiver bytes into 3-byte mouse packets. Decodes the
//            buttons and the signed movement, and keeps a clamped cursor position.
// Option   : `define PS2_MOUSE_PACKET_TIMEOUT_EN drops a partial packet when the
//            gap between two of its bytes reaches TIMEOUT_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_packet_decoder #(
    parameter int X_MAX          = 319,
    parameter int Y_MAX          = 239,
    parameter int X_INIT         = 160,
    parameter int Y_INIT         = 120,
    parameter int X_SHIFT        = 1,
    parameter int Y_SHIFT        = 1,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [9:0] x_position,
    output logic [8:0] y_position,
    output logic       left_button,
    output logic       right_button,
    output logic       middle_button,
    output logic       packet_valid,
    output logic       sync_error
);

    localparam logic signed [11:0] c_X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] c_Y_MAX_S = 12'(Y_MAX);

    // Out-of-range parameters are rejected when the design is elaborated
    if (X_SHIFT < 0 || X_SHIFT > 4 || Y_SHIFT < 0 || Y_SHIFT > 4 ||
        TIMEOUT_CYCLES < 1 || X_INIT > X_MAX || Y_INIT > Y_MAX) begin : g_param_check
        $error("ps2_mouse_packet_decoder: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_WAIT_B1 = 2'd0,
        ST_WAIT_B2 = 2'd1,
        ST_WAIT_B3 = 2'd2,
        ST_UPDATE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_b1_hi;       // first byte bits 7:4 (Y ovf, X ovf, Y sign, X sign)
    logic [2:0]  r_b1_btn;      // first byte bits 2:0 (middle, right, left)
    logic [7:0]  r_b2;
    logic [7:0]  r_b3;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [2:0]  r_btn;
    logic        r_packet_valid;
    logic        r_sync_error;
    logic        r_pend_error;  // bad header seen during UPDATE, reported one cycle late

`ifdef PS2_MOUSE_PACKET_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
    logic [c_CNT_W-1:0] r_cnt;
`endif

    logic               w_hdr_ok;
    logic signed [8:0]  w_dx;
    logic signed [8:0]  w_dy;
    logic signed [8:0]  w_sdx;
    logic signed [8:0]  w_sdy;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic [9:0]         w_x_next;
    logic [8:0]         w_y_next;

    // Header qualification, movement decode and clamped next position
    always_comb begin
        // Bit 3 is always set in a real header; ACK and self-test codes are rejected explicitly
        w_hdr_ok = received_data[3] && (received_data != 8'hFA) && (received_data != 8'hAA);
        w_dx     = r_b1_hi[2] ? 9'sd0 : $signed({r_b1_hi[0], r_b2});
        w_dy     = r_b1_hi[3] ? 9'sd0 : $signed({r_b1_hi[1], r_b3});
        w_sdx    = w_dx >>> X_SHIFT;
        w_sdy    = w_dy >>> Y_SHIFT;
        w_nx     = $signed({2'b00, r_x}) + $signed({{3{w_sdx[8]}}, w_sdx});
        // PS/2 reports +y as up while screen y grows downward
        w_ny     = $signed({3'b000, r_y}) - $signed({{3{w_sdy[8]}}, w_sdy});
        w_x_next = w_nx[9:0];
        w_y_next = w_ny[8:0];
        if (w_nx < 12'sd0) begin
            w_x_next = '0;
        end else if (w_nx > c_X_MAX_S) begin
            w_x_next = c_X_MAX_S[9:0];
        end
        if (w_ny < 12'sd0) begin
            w_y_next = '0;
        end else if (w_ny > c_Y_MAX_S) begin
            w_y_next = c_Y_MAX_S[8:0];
        end
    end

    // Packet framing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_WAIT_B1;
            r_b1_hi        <= '0;
            r_b1_btn       <= '0;
            r_b2           <= '0;
            r_b3           <= '0;
            r_x            <= 10'(X_INIT);
            r_y            <= 9'(Y_INIT);
            r_btn          <= '0;
            r_packet_valid <= 1'b0;
            r_sync_error   <= 1'b0;
            r_pend_error   <= 1'b0;
`ifdef PS2_MOUSE_PACKET_TIMEOUT_EN
            r_cnt          <= '0;
`endif
        end else begin
            r_packet_valid <= 1'b0;
            r_sync_error   <= 1'b0;
            r_pend_error   <= 1'b0;
            case (r_state)
                ST_WAIT_B1: begin
                    r_sync_error <= r_pend_error;
                    if (received_data_en) begin
                        if (w_hdr_ok) begin
                            r_b1_hi  <= received_data[7:4];
                            r_b1_btn <= received_data[2:0];
                            r_state  <= ST_WAIT_B2;
`ifdef PS2_MOUSE_PACKET_TIMEOUT_EN
                            r_cnt    <= '0;
`endif
                        end else begin
                            r_sync_error <= 1'b1;
                        end
                    end
                end
                ST_WAIT_B2: begin
                    if (received_data_en) begin
                        r_b2    <= received_data;
                        r_state <= ST_WAIT_B3;
`ifdef PS2_MOUSE_PACKET_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_state      <= ST_WAIT_B1;
                        r_sync_error <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                ST_WAIT_B3: begin
                    if (received_data_en) begin
                        r_b3    <= received_data;
                        r_state <= ST_UPDATE;
`ifdef PS2_MOUSE_PACKET_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_state      <= ST_WAIT_B1;
                        r_sync_error <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    // UPDATE: commit the packet; a byte arriving now is a header candidate
                    r_x            <= w_x_next;
                    r_y            <= w_y_next;
                    r_btn          <= r_b1_btn;
                    r_packet_valid <= 1'b1;
                    r_state        <= ST_WAIT_B1;
                    if (received_data_en) begin
                        if (w_hdr_ok) begin
                            r_b1_hi  <= received_data[7:4];
                            r_b1_btn <= received_data[2:0];
                            r_state  <= ST_WAIT_B2;
`ifdef PS2_MOUSE_PACKET_TIMEOUT_EN
                            r_cnt    <= '0;
`endif
                        end else begin
                            // Deferred so it never coincides with packet_valid
                            r_pend_error <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign x_position    = r_x;
    assign y_position    = r_y;
    assign left_button   = r_btn[0];
    assign right_button  = r_btn[1];
    assign middle_button = r_btn[2];
    assign packet_valid  = r_packet_valid;
    assign sync_error    = r_sync_error;

endmodule
`default_nettype wire
